// File: rtl/lc3b_assoc_cache.sv
// N-way set-associative write-back cache for LC-3b: 16-bit CPU port, 128-bit line memory port.
// Tree pseudo-LRU with invalid-way preference; define CACHE_STATS_EN for hit/miss/writeback counters.
module lc3b_assoc_cache #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    input  logic         pmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    output logic [127:0] pmem_wdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count,
    output logic [15:0]  wb_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 12 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2} state_t;

    state_t           state_r;
    logic [WAY_W-1:0] victim_r;
    logic             replay_r;
    logic [SETS-1:0]  valid_r [WAYS];
    logic [SETS-1:0]  dirty_r [WAYS];
    // Tree node n (heap order, root = 1) lives in bit n; bit 0 is never used.
    logic [WAYS-1:0]  plru_r [SETS];
    logic [TAG_W-1:0] tag_r [WAYS][SETS];
    logic [127:0]     data_r [WAYS][SETS];

    logic             req_s;
    logic             hit_s;
    logic             inv_found_s;
    logic             victim_dirty_s;
    logic             unused_s;
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [6:0]       word_off_s;
    logic [WAY_W-1:0] hit_way_s;
    logic [WAY_W-1:0] inv_way_s;
    logic [WAY_W-1:0] miss_way_s;
    logic [127:0]     hit_line_s;
    logic [127:0]     merged_line_s;
    logic [15:0]      hit_word_s;
    logic [15:0]      merged_word_s;

    // Walk the tree following the stored direction bits (0 = left subtree).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] bits);
        logic [WAYS-1:0] sh;
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            sh = bits >> node;
            node = 2 * node + int'(sh[0]);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Make every node on the path to 'way' point to the opposite subtree.
    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits, input logic [WAY_W-1:0] way);
        logic [WAYS-1:0]  one_hot;
        logic [WAY_W-1:0] w_sh;
        logic             dir;
        int               node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            w_sh    = way >> (WAY_W - 1 - l);
            dir     = w_sh[0];
            one_hot = {{(WAYS-1){1'b0}}, 1'b1} << node;
            bits    = dir ? (bits & ~one_hot) : (bits | one_hot);
            node    = 2 * node + int'(dir);
        end
        return bits;
    endfunction

    assign req_s      = mem_read | mem_write;
    assign idx_s      = mem_address[3+IDX_W:4];
    assign tag_s      = mem_address[15:4+IDX_W];
    assign word_off_s = {mem_address[3:1], 4'b0000};
    assign unused_s   = mem_address[0];

    // Tag compare across ways; descending scan leaves the lowest invalid way.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = {WAY_W{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_s       = hit_s | (valid_r[w][idx_s] & (tag_r[w][idx_s] == tag_s));
            hit_way_s   = (valid_r[w][idx_s] & (tag_r[w][idx_s] == tag_s)) ? WAY_W'(w) : hit_way_s;
            inv_found_s = inv_found_s | ~valid_r[w][idx_s];
            inv_way_s   = ~valid_r[w][idx_s] ? WAY_W'(w) : inv_way_s;
        end
    end

    assign miss_way_s     = inv_found_s ? inv_way_s : plru_victim(plru_r[idx_s]);
    assign victim_dirty_s = valid_r[miss_way_s][idx_s] & dirty_r[miss_way_s][idx_s];
    assign hit_line_s     = data_r[hit_way_s][idx_s];
    assign hit_word_s     = hit_line_s[word_off_s +: 16];
    assign merged_word_s  = {mem_byte_enable[1] ? mem_wdata[15:8] : hit_word_s[15:8],
                             mem_byte_enable[0] ? mem_wdata[7:0]  : hit_word_s[7:0]};

    // Write-hit line image with the enabled bytes merged in.
    always_comb begin
        merged_line_s = hit_line_s;
        merged_line_s[word_off_s +: 16] = merged_word_s;
    end

    // CPU response and memory-side drive, decoded from the current state.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        case (state_r)
            IDLE: begin
                mem_resp  = req_s & hit_s;
                mem_rdata = (req_s & hit_s) ? hit_word_s : 16'h0000;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_r[victim_r][idx_s], idx_s, 4'b0000};
                pmem_wdata   = data_r[victim_r][idx_s];
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag_s, idx_s, 4'b0000};
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

    // Control FSM plus valid/dirty/PLRU metadata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            victim_r <= {WAY_W{1'b0}};
            replay_r <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= {SETS{1'b0}};
                dirty_r[w] <= {SETS{1'b0}};
            end
            for (int s = 0; s < SETS; s++) begin
                plru_r[s] <= {WAYS{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    replay_r <= 1'b0;
                    if (req_s && hit_s) begin
                        plru_r[idx_s] <= plru_touch(plru_r[idx_s], hit_way_s);
                        if (mem_write) begin
                            dirty_r[hit_way_s][idx_s] <= 1'b1;
                        end
                    end else if (req_s) begin
                        victim_r <= miss_way_s;
                        state_r  <= victim_dirty_s ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_r[victim_r][idx_s] <= 1'b0;
                        state_r <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_r[victim_r][idx_s] <= 1'b1;
                        dirty_r[victim_r][idx_s] <= 1'b0;
                        replay_r <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Line data and tags; valid bits gate every use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && mem_write && hit_s) begin
            data_r[hit_way_s][idx_s] <= merged_line_s;
        end else if (state_r == FILL && pmem_resp) begin
            data_r[victim_r][idx_s] <= pmem_rdata;
            tag_r[victim_r][idx_s]  <= tag_s;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating event counters; replayed hits after a fill are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
            wb_count   <= 16'h0000;
        end else begin
            if (state_r == IDLE && req_s && hit_s && !replay_r && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (state_r == IDLE && req_s && !hit_s && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (state_r == WRITEBACK && pmem_resp && wb_count != 16'hFFFF)
                wb_count <= wb_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_lc3b_assoc_cache.sv
// Randomized bench for lc3b_assoc_cache against a timestamp-based set/way reference model.
module tb_lc3b_assoc_cache;
    localparam int WAYS  = 4;
    localparam int SETS  = 4;
    localparam int IDX_W = $clog2(SETS);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = 2'b00;
    logic [15:0]  mem_address = 16'h0000;
    logic [15:0]  mem_wdata = 16'h0000;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_resp = 1'b0;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata = 128'h0;
    logic [127:0] pmem_wdata;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
    logic [15:0]  wb_count;
`endif

    always #5 clk = ~clk;

    lc3b_assoc_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per set/way line address, data, flags and last-use time.
    logic         m_valid [SETS][WAYS];
    logic         m_dirty [SETS][WAYS];
    logic [15:0]  m_laddr [SETS][WAYS];
    logic [127:0] m_data  [SETS][WAYS];
    longint       m_stamp [SETS][WAYS];
    longint       m_time = 1;
    logic [127:0] mem_lines [int];
    int           m_hits, m_misses, m_wbs;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] backing(input logic [15:0] laddr);
        logic [127:0] l;
        if (mem_lines.exists(int'(laddr))) return mem_lines[int'(laddr)];
        for (int i = 0; i < 8; i++) l[i*16 +: 16] = laddr ^ 16'(i * 16'h1111) ^ 16'hC0DE;
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    // Lowest invalid way; otherwise descend, at each span leaving the half
    // that holds its most recently used way (left if nothing used since reset).
    function automatic int model_victim(input int s);
        int lo, hi, mid, best_w;
        longint best;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; hi = WAYS;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            best = 0; best_w = -1;
            for (int w = lo; w < hi; w++)
                if (m_stamp[s][w] > best) begin best = m_stamp[s][w]; best_w = w; end
            if (best_w < 0 || best_w >= mid) hi = mid;
            else lo = mid;
        end
        return lo;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_resp"}, mem_resp, 1'b0);
        check_eq({tag, "_prd"}, pmem_read, 1'b0);
        check_eq({tag, "_pwr"}, pmem_write, 1'b0);
        check_eq({tag, "_paddr"}, pmem_address, 16'h0000);
    endtask

    // Present one request at a negedge and service it to completion.
    task automatic do_access(input logic wr, input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd);
        int s, hw, v, word, dly;
        logic [15:0]  laddr;
        logic [127:0] line;
        s = int'(addr[3+IDX_W:4]);
        laddr = {addr[15:4], 4'h0};
        word = int'(addr[3:1]);
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_laddr[s][w] == laddr) hw = w;
        mem_write = wr;
        mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        #1;
        if (hw < 0) begin
            check_eq("miss_resp", mem_resp, 1'b0);
            v = model_victim(s);
            m_misses++;
            @(negedge clk);
            if (m_valid[s][v] && m_dirty[s][v]) begin
                check_eq("wb_pwr", pmem_write, 1'b1);
                check_eq("wb_prd", pmem_read, 1'b0);
                check_eq("wb_addr", pmem_address, m_laddr[s][v]);
                check_eq("wb_data", pmem_wdata, m_data[s][v]);
                dly = $urandom_range(0, 3);
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    check_eq("wb_hold", pmem_write, 1'b1);
                end
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp = 1'b0;
                mem_lines[int'(m_laddr[s][v])] = m_data[s][v];
                m_dirty[s][v] = 1'b0;
                m_wbs++;
            end
            check_eq("fill_prd", pmem_read, 1'b1);
            check_eq("fill_pwr", pmem_write, 1'b0);
            check_eq("fill_addr", pmem_address, laddr);
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check_eq("fill_hold", pmem_read, 1'b1);
            end
            pmem_resp = 1'b1;
            pmem_rdata = backing(laddr);
            @(negedge clk);
            pmem_resp = 1'b0;
            pmem_rdata = {4{$urandom()}};
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_laddr[s][v] = laddr;
            m_data[s][v] = backing(laddr);
            hw = v;
            #1;
        end else begin
            m_hits++;
        end
        check_eq("hit_resp", mem_resp, 1'b1);
        check_eq("hit_pmem", {pmem_read, pmem_write}, 2'b00);
        line = m_data[s][hw];
        if (!wr) begin
            check_eq("rdata", mem_rdata, line[word*16 +: 16]);
        end else begin
            if (be[0]) line[word*16 +: 8] = wd[7:0];
            if (be[1]) line[word*16 + 8 +: 8] = wd[15:8];
            m_data[s][hw] = line;
            m_dirty[s][hw] = 1'b1;
        end
        m_stamp[s][hw] = m_time;
        m_time++;
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
        #1;
        check_idle_outputs("after");
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        check_eq({tag, "_hits"}, hit_count, 16'(m_hits));
        check_eq({tag, "_misses"}, miss_count, 16'(m_misses));
        check_eq({tag, "_wbs"}, wb_count, 16'(m_wbs));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        logic [127:0] l;
        logic [15:0]  a;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("reset");
        check_eq("reset_wdata", pmem_wdata, 128'h0);
        check_eq("reset_rdata", mem_rdata, 16'h0000);
        check_stats("reset");

        // Cold read with a known word, then hit and byte-merge write.
        l = backing(16'h1230);
        l[47:32] = 16'hBEEF;
        mem_lines[int'(16'h1230)] = l;
        do_access(1'b0, 16'h1234, 2'b00, 16'h0000);
        do_access(1'b0, 16'h1234, 2'b00, 16'h0000);
        do_access(1'b1, 16'h1234, 2'b01, 16'hA5C3);
        do_access(1'b0, 16'h1234, 2'b00, 16'h0000);
        check_stats("cold");

        // Fill all ways of set 0 dirty, touch 0,1,2,3,0, then force an eviction.
        for (int w = 0; w < 4; w++) do_access(1'b1, 16'(w * 16'h0040), 2'b11, 16'(16'h1000 + w));
        for (int w = 0; w < 5; w++) do_access(1'b0, 16'((w % 4) * 16'h0040), 2'b00, 16'h0000);
        do_access(1'b0, 16'h0100, 2'b00, 16'h0000);
        do_access(1'b0, 16'h0080, 2'b00, 16'h0000);
        check_stats("plru");

        // Random traffic over a small tag pool to force conflicts and evictions.
        for (int n = 0; n < 400; n++) begin
            a = 16'(($urandom_range(0, 7) << (4 + IDX_W)) | ($urandom_range(0, SETS - 1) << 4)
                    | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
            do_access(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, a, 2'($urandom_range(0, 3)), 16'($urandom()));
        end
        check_stats("random");

        // Reset while a fill is outstanding drops pmem_read at once.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 16'h0250;
        #1;
        check_eq("rst_miss", mem_resp, 1'b0);
        @(negedge clk);
        check_eq("rst_fill", pmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_drop", pmem_read, 1'b0);
        check_eq("rst_paddr", pmem_address, 16'h0000);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b0, 16'h0250, 2'b00, 16'h0000);
        do_access(1'b0, 16'h0252, 2'b00, 16'h0000);
        check_stats("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
